// File: rtl/trdb_pkg.sv
// Shared trace-debugger constants: datapath width and packet buffer defaults,
// kept here so the trace debugger and its buffer instantiation agree.
package trdb_pkg;

    localparam int XLEN                  = 32;
    localparam int TRDB_BUF_DEPTH        = 16;
    localparam int TRDB_BUF_STALL_MARGIN = 4;

endpackage

// File: rtl/trdb_fifo_mem.sv
// DEPTH x XLEN register array for the packet buffer: one synchronous write
// port and one asynchronous read port. Contents are deliberately not reset.
module trdb_fifo_mem
    import trdb_pkg::*;
#(
    parameter int DEPTH = TRDB_BUF_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/trdb_packet_buffer.sv
// Elastic FIFO behind the trace packetizer: absorbs beats that cannot be
// backpressured, raises stall ahead of full, and drops and counts overflow.
module trdb_packet_buffer
    import trdb_pkg::*;
#(
    parameter int DEPTH        = TRDB_BUF_DEPTH,
    parameter int STALL_MARGIN = TRDB_BUF_STALL_MARGIN,
    parameter int CNTW         = 16,
    localparam int AW          = $clog2(DEPTH),
    localparam int FW          = AW + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic [XLEN-1:0] packet_word_i,
    input  logic            packet_word_valid_i,
    output logic [XLEN-1:0] data_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic            stall_o,
    output logic [FW-1:0]   fill_o,
    output logic            overflow_o,
    output logic [CNTW-1:0] drop_cnt_o
);

    localparam logic [FW-1:0] FULL_LVL  = FW'(DEPTH);
    localparam logic [FW-1:0] STALL_LVL = FW'(DEPTH - STALL_MARGIN);

    logic [AW-1:0]   wptr, rptr;
    logic [FW-1:0]   fill, fill_next;
    logic [XLEN-1:0] rdata;
    logic            full, push, pop, drop;

    // Sink handshake: a word transfers on every edge where valid_o and ready_i
    // are both high; until then valid_o stays high and data_o is held stable.
    assign full = (fill == FULL_LVL);
    assign pop  = valid_o & ready_i;
    // A pop in the same cycle frees a slot, so a full buffer still accepts.
    assign push = packet_word_valid_i & (~full | pop);
    assign drop = packet_word_valid_i & full & ~pop;

    always_comb begin
        fill_next = fill;
        if (push && !pop) begin
            fill_next = fill + FW'(1);
        end else if (pop && !push) begin
            fill_next = fill - FW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
            fill <= '0;
        end else if (flush_i) begin
            wptr <= '0;
            rptr <= '0;
            fill <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            fill <= fill_next;
        end
    end

    // Stall is registered off the next occupancy so it leads the full point.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_o <= 1'b0;
        end else if (flush_i) begin
            stall_o <= 1'b0;
        end else begin
            stall_o <= (fill_next >= STALL_LVL);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (flush_i) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (drop_cnt_o != {CNTW{1'b1}}) begin
                drop_cnt_o <= drop_cnt_o + CNTW'(1);
            end
        end
    end

    trdb_fifo_mem #(
        .DEPTH (DEPTH)
    ) i_mem (
        .clk_i   (clk_i),
        .we_i    (push & ~flush_i),
        .waddr_i (wptr),
        .wdata_i (packet_word_i),
        .raddr_i (rptr),
        .rdata_o (rdata)
    );

    assign valid_o = (fill != '0);
    assign data_o  = valid_o ? rdata : '0;
    assign fill_o  = fill;

endmodule

// File: tb/tb_trdb_packet_buffer.sv
// Directed bench for trdb_packet_buffer: a default-sized instance plus a
// CNTW=2 instance for drop-counter saturation.
module tb_trdb_packet_buffer;
    import trdb_pkg::*;

    logic            clk;
    logic            rst_n;

    logic            a_flush, a_valid, a_ready;
    logic [XLEN-1:0] a_word;
    logic [XLEN-1:0] a_data;
    logic            a_valid_o, a_stall, a_ovf;
    logic [4:0]      a_fill;
    logic [15:0]     a_drop;

    logic            b_flush, b_valid, b_ready;
    logic [XLEN-1:0] b_word;
    logic [XLEN-1:0] b_data;
    logic            b_valid_o, b_stall, b_ovf;
    logic [4:0]      b_fill;
    logic [1:0]      b_drop;

    logic [XLEN-1:0] exp_q[$];
    int              n_cmp;
    int              n_err;

    trdb_packet_buffer #(.DEPTH(16), .STALL_MARGIN(4), .CNTW(16)) dut_a (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .flush_i             (a_flush),
        .packet_word_i       (a_word),
        .packet_word_valid_i (a_valid),
        .data_o              (a_data),
        .valid_o             (a_valid_o),
        .ready_i             (a_ready),
        .stall_o             (a_stall),
        .fill_o              (a_fill),
        .overflow_o          (a_ovf),
        .drop_cnt_o          (a_drop)
    );

    trdb_packet_buffer #(.DEPTH(16), .STALL_MARGIN(4), .CNTW(2)) dut_b (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .flush_i             (b_flush),
        .packet_word_i       (b_word),
        .packet_word_valid_i (b_valid),
        .data_o              (b_data),
        .valid_o             (b_valid_o),
        .ready_i             (b_ready),
        .stall_o             (b_stall),
        .fill_o              (b_fill),
        .overflow_o          (b_ovf),
        .drop_cnt_o          (b_drop)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // advance one edge; outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_flush_now();
        a_flush = 1'b1;
        step();
        a_flush = 1'b0;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        a_flush = 1'b0; a_valid = 1'b0; a_ready = 1'b0; a_word = '0;
        b_flush = 1'b0; b_valid = 1'b0; b_ready = 1'b0; b_word = '0;

        #3;
        check("rst_valid", a_valid_o, 1'b0);
        check("rst_data", a_data, 0);
        check("rst_fill", a_fill, 0);
        check("rst_stall", a_stall, 1'b0);
        check("rst_ovf", a_ovf, 1'b0);
        check("rst_drop", a_drop, 0);
        rst_n = 1'b1;
        step();

        // single word, first-word fall-through from the array
        a_valid = 1'b1; a_word = 32'hDEADBEEF;
        step();
        a_valid = 1'b0;
        check("single_valid", a_valid_o, 1'b1);
        check("single_data", a_data, 32'hDEADBEEF);
        check("single_fill", a_fill, 1);
        step();
        check("single_hold", a_data, 32'hDEADBEEF);
        a_ready = 1'b1;
        step();
        a_ready = 1'b0;
        check("single_empty_valid", a_valid_o, 1'b0);
        check("single_empty_data", a_data, 0);

        // stall threshold at 12 of 16
        a_valid = 1'b1;
        for (int i = 0; i < 11; i++) begin
            a_word = 32'h100 + i;
            step();
        end
        check("stall_at11", a_stall, 1'b0);
        a_word = 32'h10B;
        step();
        a_valid = 1'b0;
        check("stall_at12", a_stall, 1'b1);
        check("stall_fill12", a_fill, 12);
        check("stall_head", a_data, 32'h100);
        a_ready = 1'b1;
        step();
        a_ready = 1'b0;
        check("stall_fall", a_stall, 1'b0);
        check("stall_fill11", a_fill, 11);
        check("stall_next_head", a_data, 32'h101);
        a_flush_now();

        // overflow: 19 words into 16 slots
        a_valid = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            a_word = i;
            if (i <= 16) exp_q.push_back(i);
            step();
        end
        a_valid = 1'b0;
        check("ovf_fill", a_fill, 16);
        check("ovf_flag", a_ovf, 1'b1);
        check("ovf_drop", a_drop, 3);

        // full with simultaneous push and pop
        a_valid = 1'b1; a_word = 32'hA5; a_ready = 1'b1;
        check("fullpp_head", a_data, exp_q.pop_front());
        exp_q.push_back(32'hA5);
        step();
        a_valid = 1'b0;
        check("fullpp_fill", a_fill, 16);
        check("fullpp_drop", a_drop, 3);

        // drain in order; last word must be 0xA5
        for (int i = 0; i < 16; i++) begin
            check("drain_valid", a_valid_o, 1'b1);
            check("drain_data", a_data, exp_q.pop_front());
            step();
        end
        a_ready = 1'b0;
        check("drain_empty", a_valid_o, 1'b0);
        check("drain_fill", a_fill, 0);
        check("drain_ovf_sticky", a_ovf, 1'b1);
        a_flush_now();
        check("flush_clr_drop", a_drop, 0);

        // flush at fill=10 with two drops, word presented in flush cycle
        a_valid = 1'b1;
        for (int i = 0; i < 18; i++) begin
            a_word = 32'h200 + i;
            step();
        end
        a_valid = 1'b0;
        a_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        a_ready = 1'b0;
        check("preflush_fill", a_fill, 10);
        check("preflush_drop", a_drop, 2);
        check("preflush_head", a_data, 32'h206);
        a_flush = 1'b1; a_valid = 1'b1; a_word = 32'hFFFF;
        step();
        a_flush = 1'b0; a_valid = 1'b0;
        check("flush_fill", a_fill, 0);
        check("flush_valid", a_valid_o, 1'b0);
        check("flush_data", a_data, 0);
        check("flush_ovf", a_ovf, 1'b0);
        check("flush_drop", a_drop, 0);
        check("flush_stall", a_stall, 1'b0);

        // saturation on the 2-bit counter, then asynchronous reset mid-stream
        a_valid = 1'b1; b_valid = 1'b1;
        for (int i = 0; i < 21; i++) begin
            a_word = i; b_word = i;
            step();
        end
        check("sat_b_drop", b_drop, 3);
        check("sat_b_ovf", b_ovf, 1'b1);
        check("sat_b_fill", b_fill, 16);
        check("sat_a_drop", a_drop, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_a_fill", a_fill, 0);
        check("arst_a_valid", a_valid_o, 1'b0);
        check("arst_a_data", a_data, 0);
        check("arst_a_stall", a_stall, 1'b0);
        check("arst_a_ovf", a_ovf, 1'b0);
        check("arst_a_drop", a_drop, 0);
        check("arst_b_drop", b_drop, 0);
        check("arst_b_fill", b_fill, 0);
        a_valid = 1'b0; b_valid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/trdb_packet_buffer.md
# trdb_packet_buffer

Elastic buffer directly downstream of the trace debugger: captures every `packet_word`/`packet_word_valid` beat the packetizer emits, which has no backpressure of its own, and re-presents the words on a valid/ready stream to the trace sink (DMA, UART or APB readout). It raises `stall` early enough that words still in flight in the packetizer pipeline land without loss. Words that arrive while full are dropped and counted.

## Interface
- `DEPTH`, 16: number of XLEN-wide entries; power of two, >= 4.
- `STALL_MARGIN`, 4: free entries reserved for in-flight words; 1 <= STALL_MARGIN < DEPTH.
- `CNTW`, 16: width of the drop counter.

- `clk_i`  in  1  single clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  synchronous clear of contents, flags and counter.
- `packet_word_i`  in  XLEN  word from the trace debugger.
- `packet_word_valid_i`  in  1  word valid; no ready, must be accepted or dropped this cycle.
- `data_o`  out  XLEN  head word; 0 when `valid_o`=0.
- `valid_o`  out  1  head word present.
- `ready_i`  in  1  sink accepts the head word.
- `stall_o`  out  1  request to upstream to stop issuing; wired to the trace debugger `stall`.
- `fill_o`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow_o`  out  1  sticky: at least one word dropped since reset/flush.
- `drop_cnt_o`  out  CNTW  dropped-word count, saturating at 2^CNTW-1.

## Operation
- push = `packet_word_valid_i` & (fill < DEPTH | pop); pop = `valid_o` & `ready_i`.
- Push writes `mem[wptr]` and increments `wptr`. Pop increments `rptr`. Both pointers are $clog2(DEPTH) bits and wrap naturally.
- fill_next = fill + push - pop. Simultaneous push and pop leaves fill unchanged, including at fill = DEPTH: the pop frees the slot, so the push is accepted.
- Drop = `packet_word_valid_i` & fill = DEPTH & !pop. A drop sets `overflow_o` and increments `drop_cnt_o`; the counter saturates and does not wrap.
- `valid_o` = (fill != 0). `data_o` = `mem[rptr]` gated to 0 when empty. First-word-fall-through applies from the array only; there is no input-to-output bypass.
- `stall_o` is registered: `stall_o` <= (fill_next >= DEPTH - STALL_MARGIN). It deasserts on the edge after fill_next drops below the threshold.
- `flush_i` has priority over push, pop and drop. On the next edge: pointers and fill are 0, `overflow_o` = 0, `drop_cnt_o` = 0, `stall_o` = 0. A word presented in the flush cycle is discarded and not counted as dropped.
- No state machine beyond the pointer/fill counters. The block is ordering-preserving FIFO.

## Timing
- Reset values: fill 0, pointers 0, `valid_o` 0, `data_o` 0, `stall_o` 0, `overflow_o` 0, `drop_cnt_o` 0, `fill_o` 0. Memory contents are not reset.
- Latency: a word pushed at edge N is visible on `data_o` with `valid_o`=1 in cycle N+1 when the buffer was empty.
- Throughput: 1 push and 1 pop per cycle, sustained.
- `valid_o` is never deasserted without a pop or flush. `data_o` is stable while `valid_o`=1 and `ready_i`=0.
- Stall contract: upstream may emit at most STALL_MARGIN words after the cycle in which `stall_o` rises. Under that contract no drop occurs.
- `rst_ni` asserted mid-operation clears all state immediately (asynchronously). In-flight words are lost and not counted.

## Structure
- `XLEN` comes from `trdb_pkg`. Add `TRDB_BUF_DEPTH` and `TRDB_BUF_STALL_MARGIN` defaults to `trdb_pkg` so top-level instantiation and the trace debugger agree.
- One sub-module is natural: `trdb_fifo_mem`, a DEPTH x XLEN register array with one write port and one asynchronous read port.
- Pointer, fill, stall, overflow and counter logic stay in `trdb_packet_buffer`.

## Test plan
- Single word: push 0xDEADBEEF into an empty buffer with `ready_i`=0 -> next cycle `valid_o`=1, `data_o`=0xDEADBEEF, `fill_o`=1. Raise `ready_i` -> the following cycle `valid_o`=0, `data_o`=0.
- Stall threshold (DEPTH=16, MARGIN=4): push 12 words with `ready_i`=0 -> `stall_o` rises the cycle after the 12th push. Pop one -> `stall_o` falls one cycle later.
- Overflow: with `ready_i`=0, push 19 words 1..19 -> `fill_o`=16, `overflow_o`=1, `drop_cnt_o`=3. Drain -> words 1..16 in order.
- Full with simultaneous push and pop: at fill=16, push 0xA5 with `ready_i`=1 -> fill stays 16, no drop, and 0xA5 is read out last.
- Flush: at fill=10 with `drop_cnt_o`=2, assert `flush_i` together with a valid word -> next cycle fill=0, `valid_o`=0, `overflow_o`=0, `drop_cnt_o`=0, `stall_o`=0.
- Saturation and reset: with CNTW=2, drop 5 words -> `drop_cnt_o`=3. Assert `rst_ni`=0 mid-stream -> all outputs are 0 immediately.
